// File: rtl/sd_cmd_tx_if.sv
// Host, CRC-stage and CMD-pad signals of the SD command transmitter.
// SD_CMD_TX_STATS_EN adds the cmd_count/err_count statistics outputs.
interface sd_cmd_tx_if;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] argument;
    logic        ready;
    logic        done;
    logic        error;
    logic        sd_clk_en;
    logic        cmd_out;
    logic        cmd_oe;
    logic        crc_load;
    logic [39:0] crc_data;
    logic [6:0]  crc_in;
    logic        crc_valid;
`ifdef SD_CMD_TX_STATS_EN
    logic [15:0] cmd_count;
    logic [7:0]  err_count;
`endif

    modport master (
        output start, cmd_index, argument, sd_clk_en, crc_in, crc_valid,
        input  ready, done, error, cmd_out, cmd_oe, crc_load, crc_data
`ifdef SD_CMD_TX_STATS_EN
        , input cmd_count, err_count
`endif
    );

    modport slave (
        input  start, cmd_index, argument, sd_clk_en, crc_in, crc_valid,
        output ready, done, error, cmd_out, cmd_oe, crc_load, crc_data
`ifdef SD_CMD_TX_STATS_EN
        , output cmd_count, err_count
`endif
    );
endinterface

// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter: fetches CRC7 for {01, index, arg}, then shifts the 48-bit frame out.
// Optional statistics counters are built when SD_CMD_TX_STATS_EN is defined.
//
// state    | meaning
// IDLE     | ready for a new command
// CRC_REQ  | one-cycle crc_load pulse to the CRC stage
// CRC_WAIT | waiting for crc_valid (first cycle ignored), bounded by CRC_TIMEOUT
// SHIFT    | driving frame bits MSB first, one per sd_clk_en
// DONE     | one-cycle done pulse, line released
module sd_cmd_tx #(
    parameter int CRC_TIMEOUT = 63,
    parameter int FRAME_BITS  = 48
) (
    input logic      clk,
    input logic      rst,
    sd_cmd_tx_if.slave bus
);
    localparam logic [5:0] TIMEOUT_LAST = 6'(CRC_TIMEOUT - 1);
    localparam logic [5:0] LAST_BIT     = 6'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CRC_REQ  = 3'd1,
        CRC_WAIT = 3'd2,
        SHIFT    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  wait_cnt_q, wait_cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [47:0] frame_q, frame_d;
    logic [39:0] crc_data_q, crc_data_d;
    logic        error_q, error_d;
    logic [5:0]  bit_idx;
    logic        capture;
`ifdef SD_CMD_TX_STATS_EN
    logic [15:0] cmd_count_q, cmd_count_d;
    logic [7:0]  err_count_q, err_count_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            crc_data_q  <= '0;
            error_q     <= 1'b0;
`ifdef SD_CMD_TX_STATS_EN
            cmd_count_q <= '0;
            err_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            crc_data_q  <= crc_data_d;
            error_q     <= error_d;
`ifdef SD_CMD_TX_STATS_EN
            cmd_count_q <= cmd_count_d;
            err_count_q <= err_count_d;
`endif
        end
    end

    // The CRC stage may still show the previous result's valid in the first wait cycle.
    assign capture = (wait_cnt_q != 6'd0) && bus.crc_valid;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        crc_data_d = crc_data_q;
        error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    crc_data_d = {2'b01, bus.cmd_index, bus.argument};
                    state_d    = CRC_REQ;
                end
            end
            CRC_REQ: begin
                wait_cnt_d = '0;
                state_d    = CRC_WAIT;
            end
            CRC_WAIT: begin
                wait_cnt_d = wait_cnt_q + 6'd1;
                if (capture) begin
                    frame_d   = {crc_data_q, bus.crc_in, 1'b1};
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.sd_clk_en) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SD_CMD_TX_STATS_EN
    always_comb begin
        cmd_count_d = cmd_count_q;
        err_count_d = err_count_q;
        if (state_q == DONE) cmd_count_d = cmd_count_q + 16'd1;
        if (error_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end

    assign bus.cmd_count = cmd_count_q;
    assign bus.err_count = err_count_q;
`endif

    // Pad controls decode registered state only, so start cannot glitch the CMD line.
    always_comb begin
        bit_idx      = LAST_BIT - bit_cnt_q;
        bus.ready    = (state_q == IDLE);
        bus.done     = (state_q == DONE);
        bus.crc_load = (state_q == CRC_REQ);
        bus.cmd_oe   = (state_q == SHIFT);
        bus.cmd_out  = (state_q == SHIFT) ? frame_q[bit_idx] : 1'b1;
        bus.error    = error_q;
        bus.crc_data = crc_data_q;
    end
endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: known SD command frames, stale valid, timeout, ignored start, reset abort.
module tb_sd_cmd_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sd_cmd_tx_if bus();

    sd_cmd_tx #(.CRC_TIMEOUT(63), .FRAME_BITS(48)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drives one command and plays the CRC stage and SD clock strobe (every 4th cycle).
    task automatic run_cmd(
        input  logic [5:0]  idx,
        input  logic [31:0] arg,
        input  logic [6:0]  crc,
        input  int          vdelay,
        input  bit          stale,
        input  bit          poke,
        input  int          rst_bit,
        input  int          post,
        output logic [47:0] frame,
        output int          nbits,
        output int          n_done,
        output int          n_err,
        output int          first_oe,
        output int          err_lat,
        output bit          oe_after,
        output bit          rdy_at_start,
        output logic [39:0] cd_load,
        output logic [39:0] cd_end,
        output bit          aborted,
        output bit          hung
    );
        int since = 0;
        bit load_seen = 0;
        bit fin = 0;
        int post_left = 0;
        frame = '0; nbits = 0; n_done = 0; n_err = 0; first_oe = -1; err_lat = -1;
        oe_after = 0; cd_load = '0; cd_end = '0; aborted = 0; hung = 0;
        @(negedge clk);
        rdy_at_start   = bus.ready;
        bus.start      = 1'b1;
        bus.cmd_index  = idx;
        bus.argument   = arg;
        bus.crc_in     = crc;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.cmd_index  = ~idx;
        bus.argument   = ~arg;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (bus.crc_load) begin
                load_seen = 1; since = 0; cd_load = bus.crc_data;
            end else if (load_seen) begin
                since++;
            end
            if (bus.cmd_oe && first_oe < 0) first_oe = since;
            if (fin && bus.cmd_oe) oe_after = 1;
            if (bus.done) n_done++;
            if (bus.error) begin
                n_err++;
                if (err_lat < 0) err_lat = since;
            end
            cd_end = bus.crc_data;
            if (!fin && (bus.done || bus.error)) begin
                fin = 1; post_left = post;
            end
            if (fin) begin
                if (post_left == 0) break;
                post_left--;
            end
            if (rst_bit >= 0 && nbits == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                aborted = 1;
                break;
            end
            bus.crc_valid = stale ? load_seen : (load_seen && vdelay >= 0 && since == vdelay);
            bus.sd_clk_en = (cyc % 4 == 3);
            if (poke && nbits == 10 && bus.cmd_oe) begin
                bus.start = 1'b1; bus.cmd_index = 6'h11; bus.argument = 32'hDEADBEEF;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.sd_clk_en && bus.cmd_oe) begin
                frame = {frame[46:0], bus.cmd_out};
                nbits++;
            end
            @(negedge clk);
        end
        hung = !fin && !aborted;
        bus.sd_clk_en = 1'b0;
        bus.crc_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    logic [47:0] fr, fr2;
    int nb, nd, ne, foe, elat;
    bit oea, rdy, abt, hng;
    logic [39:0] cdl, cde;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error); end
        checks++; if ({bus.cmd_out, bus.cmd_oe} !== 2'b10) begin errors++; $display("FAIL reset_pad got out=%b oe=%b want out=1 oe=0", bus.cmd_out, bus.cmd_oe); end
        checks++; if (bus.crc_load !== 1'b0) begin errors++; $display("FAIL reset_crc_load got %b want 0", bus.crc_load); end
        checks++; if (bus.crc_data !== 40'h0) begin errors++; $display("FAIL reset_crc_data got %h want 0", bus.crc_data); end
`ifdef SD_CMD_TX_STATS_EN
        checks++; if ({bus.cmd_count, bus.err_count} !== 24'h0) begin errors++; $display("FAIL reset_stats got %h/%h want 0/0", bus.cmd_count, bus.err_count); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        run_cmd(6'd0, 32'h0, 7'h4A, 3, 0, 0, 20, 2, fr, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        checks++; if (abt !== 1'b1 || nb != 20) begin errors++; $display("FAIL rstmid_reached got aborted=%b bits=%0d want 1/20", abt, nb); end
        checks++; if ({bus.cmd_out, bus.cmd_oe, bus.ready, bus.done} !== 4'b1010) begin errors++; $display("FAIL rstmid_outputs got out=%b oe=%b rdy=%b done=%b want 1 0 1 0", bus.cmd_out, bus.cmd_oe, bus.ready, bus.done); end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.error || bus.cmd_oe) bad++;
        end
        checks++; if (bad != 0 || nd != 0) begin errors++; $display("FAIL rstmid_quiet got %0d late pulses, %0d done want 0", bad, nd); end
    endtask

    task automatic test_cmd0();
        run_cmd(6'd0, 32'h0, 7'h4A, 3, 0, 0, -1, 2, fr, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        checks++; if (cdl !== 40'h4000000000) begin errors++; $display("FAIL cmd0_crc_data got %h want 4000000000", cdl); end
        checks++; if (fr !== 48'h400000000095 || nb != 48) begin errors++; $display("FAIL cmd0_frame got %h (%0d bits) want 400000000095 (48)", fr, nb); end
        checks++; if (nd != 1 || hng) begin errors++; $display("FAIL cmd0_done got %0d pulses hung=%b want 1", nd, hng); end
        checks++; if (oea !== 1'b0) begin errors++; $display("FAIL cmd0_oe_after got %b want 0", oea); end
        checks++; if (foe != 4) begin errors++; $display("FAIL cmd0_shift_latency got %0d want 4", foe); end
    endtask

    task automatic test_cmd8();
        run_cmd(6'd8, 32'h000001AA, 7'h43, 3, 0, 0, -1, 2, fr, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        checks++; if (fr !== 48'h48000001AA87) begin errors++; $display("FAIL cmd8_frame got %h want 48000001AA87", fr); end
        checks++; if (cdl !== 40'h48000001AA) begin errors++; $display("FAIL cmd8_crc_data got %h want 48000001AA", cdl); end
    endtask

    task automatic test_cmd17();
        run_cmd(6'd17, 32'h0, 7'h2A, 3, 0, 0, -1, 2, fr, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        checks++; if (fr !== 48'h510000000055) begin errors++; $display("FAIL cmd17_frame got %h want 510000000055", fr); end
        checks++; if (nd != 1) begin errors++; $display("FAIL cmd17_done got %0d want 1", nd); end
    endtask

    task automatic test_stale_valid();
        run_cmd(6'd0, 32'h0, 7'h4A, 0, 1, 0, -1, 2, fr, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        checks++; if (foe != 3) begin errors++; $display("FAIL stale_capture_cycle got %0d want 3", foe); end
        checks++; if (fr !== 48'h400000000095) begin errors++; $display("FAIL stale_frame got %h want 400000000095", fr); end
    endtask

    task automatic test_timeout();
        run_cmd(6'd5, 32'h12345678, 7'h00, -1, 0, 0, -1, 2, fr, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        checks++; if (ne != 1 || elat != 64) begin errors++; $display("FAIL timeout_error got %0d pulses at %0d want 1 at 64", ne, elat); end
        checks++; if (nd != 0 || foe != -1) begin errors++; $display("FAIL timeout_no_tx got done=%0d oe_at=%0d want 0/-1", nd, foe); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL timeout_ready got %b want 1", bus.ready); end
    endtask

    task automatic test_start_during_shift();
        int loads = 0;
        run_cmd(6'd8, 32'h000001AA, 7'h43, 3, 0, 1, -1, 2, fr, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        checks++; if (fr !== 48'h48000001AA87) begin errors++; $display("FAIL poke_frame got %h want 48000001AA87", fr); end
        checks++; if (cde !== 40'h48000001AA) begin errors++; $display("FAIL poke_crc_data got %h want 48000001AA", cde); end
        repeat (3) begin
            @(negedge clk);
            if (bus.crc_load || !bus.ready) loads++;
        end
        checks++; if (loads != 0 || nd != 1) begin errors++; $display("FAIL poke_not_queued got %0d busy cycles, %0d done want 0/1", loads, nd); end
    endtask

    task automatic test_back_to_back();
        run_cmd(6'd17, 32'h0, 7'h2A, 3, 0, 0, -1, 0, fr, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        run_cmd(6'd8, 32'h000001AA, 7'h43, 3, 0, 0, -1, 2, fr2, nb, nd, ne, foe, elat, oea, rdy, cdl, cde, abt, hng);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", rdy); end
        checks++; if (fr !== 48'h510000000055 || fr2 !== 48'h48000001AA87) begin errors++; $display("FAIL b2b_frames got %h %h want 510000000055 48000001AA87", fr, fr2); end
    endtask

`ifdef SD_CMD_TX_STATS_EN
    task automatic test_stats();
        checks++; if (bus.cmd_count !== 16'd7) begin errors++; $display("FAIL stats_cmd_count got %0d want 7", bus.cmd_count); end
        checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL stats_err_count got %0d want 1", bus.err_count); end
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.cmd_index = '0; bus.argument = '0;
        bus.sd_clk_en = 1'b0; bus.crc_in = '0; bus.crc_valid = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_cmd0();
        test_cmd8();
        test_cmd17();
        test_stale_valid();
        test_timeout();
        test_start_during_shift();
        test_back_to_back();
`ifdef SD_CMD_TX_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
